// File: rtl/aes_pkg.sv
// Shared AES controller definitions: opcodes, decrypt FSM states, round constants.
// Common to the encryption and decryption sequencing controllers.
package aes_pkg;

    typedef logic [31:0] aes_32;

    typedef enum logic [2:0] {
        NOOP       = 3'd0,
        AESENC     = 3'd1,
        AESENCLAST = 3'd2,
        AESKEYGEN  = 3'd3,
        AESDEC     = 3'd4,
        AESDECLAST = 3'd5,
        AESIMC     = 3'd6,
        AESDECFULL = 3'd7
    } opcode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SBOX   = 2'd1,
        ROUND  = 2'd2,
        FINISH = 2'd3
    } aes_dec_state_t;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] AES_RCON_LAST = 8'h36;

    // Inverse of the forward xtime step: 0x80 -> 0x1b wraps, so 0x1b steps back to 0x80.
    function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
        return (rc == 8'h1b) ? 8'h80 : {1'b0, rc[7:1]};
    endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Request/ready handshake between an issuer and the AES decryption controller.
// abort_i exists only when AES_DEC_ABORT_EN is defined.
interface aes_dec_ctrl_if;
    import aes_pkg::*;

    logic  start_i;
    opcode opcode_i;
    logic  busy_o;
    logic  plain_ready_o;
    logic  key_ready_o;
`ifdef AES_DEC_ABORT_EN
    logic  abort_i;

    modport master (output start_i, opcode_i, abort_i,
                    input  busy_o, plain_ready_o, key_ready_o);
    modport slave  (input  start_i, opcode_i, abort_i,
                    output busy_o, plain_ready_o, key_ready_o);
`else
    modport master (output start_i, opcode_i,
                    input  busy_o, plain_ready_o, key_ready_o);
    modport slave  (input  start_i, opcode_i,
                    output busy_o, plain_ready_o, key_ready_o);
`endif

endinterface

// File: rtl/aes_dec_rcon.sv
// Backward round-constant register: load restarts at the last forward rcon,
// step walks one round back.
module aes_dec_rcon
    import aes_pkg::*;
#(
    parameter logic [7:0] RCON_LAST = AES_RCON_LAST
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_LAST;
        end else if (step_i) begin
            rcon_d = rcon_prev(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rcon_q <= RCON_LAST;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_dec_ctrl.sv
// AES decryption sequencing controller (AESDEC/AESDECLAST/AESIMC/AESDECFULL).
// Optional abort input enabled by AES_DEC_ABORT_EN.
module aes_dec_ctrl
    import aes_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter logic [7:0] RCON_LAST = AES_RCON_LAST
) (
    input  logic              clk,
    input  logic              nrst,
    aes_dec_ctrl_if.slave     bus,
    output logic              inv_mix_o,
    output logic              zero_rnd_o,
    output logic              final_rnd_o,
    output logic              key_sel_o,
    output logic              key_sub_o,
    output logic              gen_key_o,
    output logic              prev_rnd_o,
    output logic [3:0]        rnd_num_o,
    output aes_32             r_con_o
);

    aes_dec_state_t state_q, state_d;
    opcode          op_q, op_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           busy_q, busy_d;
    logic           inv_mix_q, inv_mix_d;
    logic           zero_rnd_q, zero_rnd_d;
    logic           final_q, final_d;
    logic           key_sel_q, key_sel_d;
    logic           key_sub_q, key_sub_d;
    logic           gen_key_q, gen_key_d;
    logic           prev_rnd_q, prev_rnd_d;
    logic           plain_ready_q, plain_ready_d;
    logic           key_ready_q, key_ready_d;
    logic           rcon_load;
    logic           rcon_step;
    logic           first_rnd;
    logic           abort;
    logic [7:0]     rcon;

`ifdef AES_DEC_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rnd_d     = rnd_q;
        rcon_load = 1'b0;
        rcon_step = 1'b0;
        first_rnd = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    case (bus.opcode_i)
                        AESDEC, AESDECLAST: begin
                            state_d = SBOX;
                            op_d    = bus.opcode_i;
                            rnd_d   = 4'd0;
                        end
                        AESIMC: begin
                            state_d = ROUND;
                            op_d    = bus.opcode_i;
                            rnd_d   = 4'd0;
                        end
                        AESDECFULL: begin
                            state_d   = SBOX;
                            op_d      = bus.opcode_i;
                            rnd_d     = 4'(NR);
                            rcon_load = 1'b1;
                            first_rnd = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            SBOX: state_d = ROUND;
            ROUND: begin
                if (op_q == AESDECFULL) begin
                    rnd_d     = rnd_q - 4'd1;
                    rcon_step = 1'b1;
                    state_d   = (rnd_q == 4'd1) ? FINISH : SBOX;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Any return to IDLE (normal or aborted) restores the reset-time context.
        if (state_q != IDLE && (state_d == IDLE || abort)) begin
            state_d   = IDLE;
            op_d      = NOOP;
            rnd_d     = 4'd0;
            rcon_load = 1'b1;
            rcon_step = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they land in the same cycle as it.
    always_comb begin
        busy_d        = (state_d != IDLE);
        inv_mix_d     = 1'b0;
        zero_rnd_d    = first_rnd;
        final_d       = 1'b0;
        key_sel_d     = 1'b0;
        key_sub_d     = (state_d == SBOX) && (op_d == AESDECFULL);
        gen_key_d     = first_rnd;
        prev_rnd_d    = 1'b0;
        plain_ready_d = 1'b0;
        key_ready_d   = 1'b0;

        if (state_d == ROUND) begin
            case (op_d)
                AESDEC:     inv_mix_d = 1'b1;
                AESDECLAST: final_d   = 1'b1;
                AESIMC:     inv_mix_d = 1'b1;
                AESDECFULL: begin
                    prev_rnd_d = 1'b1;
                    key_sel_d  = 1'b1;
                    final_d    = (rnd_d == 4'd1);
                    inv_mix_d  = (rnd_d != 4'd1);
                end
                default: ;
            endcase
        end

        if (state_d == FINISH) begin
            key_ready_d   = (op_d == AESIMC);
            plain_ready_d = (op_d != AESIMC);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= IDLE;
            op_q          <= NOOP;
            rnd_q         <= 4'd0;
            busy_q        <= 1'b0;
            inv_mix_q     <= 1'b0;
            zero_rnd_q    <= 1'b0;
            final_q       <= 1'b0;
            key_sel_q     <= 1'b0;
            key_sub_q     <= 1'b0;
            gen_key_q     <= 1'b0;
            prev_rnd_q    <= 1'b0;
            plain_ready_q <= 1'b0;
            key_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rnd_q         <= rnd_d;
            busy_q        <= busy_d;
            inv_mix_q     <= inv_mix_d;
            zero_rnd_q    <= zero_rnd_d;
            final_q       <= final_d;
            key_sel_q     <= key_sel_d;
            key_sub_q     <= key_sub_d;
            gen_key_q     <= gen_key_d;
            prev_rnd_q    <= prev_rnd_d;
            plain_ready_q <= plain_ready_d;
            key_ready_q   <= key_ready_d;
        end
    end

    aes_dec_rcon #(
        .RCON_LAST (RCON_LAST)
    ) u_rcon (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (rcon_load),
        .step_i (rcon_step),
        .rcon_o (rcon)
    );

    assign bus.busy_o        = busy_q;
    assign bus.plain_ready_o = plain_ready_q;
    assign bus.key_ready_o   = key_ready_q;
    assign inv_mix_o         = inv_mix_q;
    assign zero_rnd_o        = zero_rnd_q;
    assign final_rnd_o       = final_q;
    assign key_sel_o         = key_sel_q;
    assign key_sub_o         = key_sub_q;
    assign gen_key_o         = gen_key_q;
    assign prev_rnd_o        = prev_rnd_q;
    assign rnd_num_o         = rnd_q;
    assign r_con_o           = {24'h0, rcon};

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Randomized bench for aes_dec_ctrl against a per-cycle behavioural model.
// Covers the abort path when AES_DEC_ABORT_EN is defined.
module tb_aes_dec_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic       inv_mix, zero_rnd, final_rnd, key_sel, key_sub, gen_key, prev_rnd;
    logic [3:0] rnd_num;
    aes_32      r_con;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_dec_ctrl_if bus ();

    aes_dec_ctrl dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus),
        .inv_mix_o   (inv_mix),
        .zero_rnd_o  (zero_rnd),
        .final_rnd_o (final_rnd),
        .key_sel_o   (key_sel),
        .key_sub_o   (key_sub),
        .gen_key_o   (gen_key),
        .prev_rnd_o  (prev_rnd),
        .rnd_num_o   (rnd_num),
        .r_con_o     (r_con)
    );

    // Vector layout: busy inv_mix zero final key_sel key_sub gen_key prev | rnd[3:0] | r_con[31:0] | plain_rdy key_rdy
    task automatic chk(input string tag, input logic [45:0] obs, input logic [45:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [45:0] obs_vec();
        return {bus.busy_o, inv_mix, zero_rnd, final_rnd, key_sel, key_sub, gen_key, prev_rnd,
                rnd_num, r_con, bus.plain_ready_o, bus.key_ready_o};
    endfunction

    function automatic logic [45:0] mk(input logic b, input logic im, input logic z, input logic f,
                                       input logic ks, input logic ku, input logic g, input logic p,
                                       input logic [3:0] rnd, input logic [7:0] rc,
                                       input logic pr, input logic kr);
        return {b, im, z, f, ks, ku, g, p, rnd, 24'h0, rc, pr, kr};
    endfunction

    function automatic logic [45:0] idle_vec();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h36, 0, 0);
    endfunction

    function automatic int lat(input opcode op);
        case (op)
            AESDEC, AESDECLAST: return 3;
            AESIMC:             return 2;
            AESDECFULL:         return 2 * AES_NR + 1;
            default:            return 0;
        endcase
    endfunction

    // Expected outputs in cycle c (1..lat) after the start edge.
    // Full decrypt visits forward rounds 10..1, each SBOX then ROUND, using that round's forward rcon.
    function automatic logic [45:0] model(input opcode op, input int c);
        logic [7:0] fwd [0:9];
        int k;
        int r;
        fwd = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        case (op)
            AESDEC, AESDECLAST: begin
                if (c == 1) return mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h36, 0, 0);
                if (c == 2) return mk(1, op == AESDEC, 0, op == AESDECLAST, 0, 0, 0, 0, 4'd0, 8'h36, 0, 0);
                return mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h36, 1, 0);
            end
            AESIMC: begin
                if (c == 1) return mk(1, 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h36, 0, 0);
                return mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h36, 0, 1);
            end
            AESDECFULL: begin
                if (c == 2 * AES_NR + 1) return mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 1, 0);
                k = (c + 1) / 2;
                r = AES_NR + 1 - k;
                if (c % 2 == 1)
                    return mk(1, 0, k == 1, 0, 0, 1, k == 1, 0, 4'(r), fwd[r-1], 0, 0);
                return mk(1, r > 1, 0, r == 1, 1, 0, 0, 1, 4'(r), fwd[r-1], 0, 0);
            end
            default: return idle_vec();
        endcase
    endfunction

    task automatic run_op(input opcode op, input bit stray);
        int n;
        n = lat(op);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.opcode_i = op;
        @(negedge clk);
        chk("pre_start", obs_vec(), idle_vec());
        @(posedge clk); #1;
        for (int c = 1; c <= n; c++) begin
            bus.start_i  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.opcode_i = opcode'($urandom_range(0, 7));
            @(negedge clk);
            chk($sformatf("%s_c%0d", op.name(), c), obs_vec(), model(op, c));
            @(posedge clk); #1;
        end
        bus.start_i  = 1'b0;
        bus.opcode_i = NOOP;
        @(negedge clk);
        chk($sformatf("%s_idle", op.name()), obs_vec(), idle_vec());
    endtask

    initial begin
        nrst         = 1'b0;
        bus.start_i  = 1'b0;
        bus.opcode_i = NOOP;
`ifdef AES_DEC_ABORT_EN
        bus.abort_i  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", obs_vec(), idle_vec());
        nrst = 1'b1;

        run_op(AESDEC, 0);
        run_op(AESIMC, 0);
        run_op(AESDECLAST, 0);
        run_op(AESDECFULL, 0);
        run_op(NOOP, 0);
        run_op(AESENC, 0);
        run_op(AESDEC, 1);
        run_op(AESIMC, 1);
        run_op(AESDECFULL, 1);

        for (int i = 0; i < 40; i++) begin
            run_op(opcode'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Reset held two cycles in the middle of a full decrypt.
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.opcode_i = AESDECFULL;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("rst_pre_c%0d", c), obs_vec(), model(AESDECFULL, c));
            @(posedge clk); #1;
        end
        nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rst_hold%0d", i), obs_vec(), idle_vec());
        end
        nrst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", i), obs_vec(), idle_vec());
        end
        run_op(AESDEC, 0);

`ifdef AES_DEC_ABORT_EN
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.opcode_i = AESDECFULL;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) bus.abort_i = 1'b1;
            @(negedge clk);
            chk($sformatf("abort_c%0d", c), obs_vec(), model(AESDECFULL, c));
            @(posedge clk); #1;
        end
        bus.abort_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("abort_after%0d", i), obs_vec(), idle_vec());
            @(posedge clk); #1;
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        chk("abort_in_idle", obs_vec(), idle_vec());
        bus.abort_i = 1'b0;
        run_op(AESDEC, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
